// File: rtl/nor2_bist_ctrl_if.sv
// Control/status and cell-side signals of the NOR2 BIST controller.
// master = requester plus cells-under-test side; slave = the controller.
`timescale 1ns/1ps

interface nor2_bist_ctrl_if #(
    parameter int NCELL = 8
);
    // start and abort are level-sampled requests on the rising clock edge with no
    // handshake back-pressure: start is honoured only while the controller sits
    // in IDLE (otherwise dropped), abort cancels a run in APPLY/SETTLE/CHECK and
    // beats a coincident start. done is a one-cycle pulse; busy frames the run.
    logic             start;
    logic             abort;
    logic [NCELL-1:0] dut_a;
    logic [NCELL-1:0] dut_b;
    logic [NCELL-1:0] dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [NCELL-1:0] fail_mask;
    logic [7:0]       err_count;
    logic [2:0]       dbg_state;

    modport master (
        output start, abort, dut_y,
        input  dut_a, dut_b, busy, done, pass, fail_mask, err_count, dbg_state
    );

    modport slave (
        input  start, abort, dut_y,
        output dut_a, dut_b, busy, done, pass, fail_mask, err_count, dbg_state
    );
endinterface

// File: rtl/nor2_bist_ctrl.sv
// BIST sequencer for an array of NOR2X1 cells: walks {a,b} = 00..11, checks Y.
// Define NOR2_BIST_ERRCNT_EN to build the saturating err_count accumulator.
`timescale 1ns/1ps

module nor2_bist_ctrl #(
    parameter int NCELL  = 8,
    parameter int SETTLE = 2
) (
    input logic               clk,
    input logic               reset,
    nor2_bist_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [1:0]       pat_q, pat_d;
    logic [3:0]       wait_q, wait_d;
    logic [NCELL-1:0] fail_q, fail_d;
    logic [NCELL-1:0] a_q, a_d;
    logic [NCELL-1:0] b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [NCELL-1:0] mism;

    // Ideal NOR of the applied pattern is the same for every cell.
    assign mism = bus.dut_y ^ {NCELL{~(pat_q[1] | pat_q[0])}};

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        wait_d  = wait_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = S_APPLY;
                    pat_d   = 2'd0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            S_APPLY: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    state_d = S_SETTLE;
                    wait_d  = SETTLE_LAST;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else if (wait_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    fail_d = fail_q | mism;
                    if (pat_q == 2'd3) begin
                        state_d = S_DONE;
                        pass_d  = (fail_d == '0);
                    end else begin
                        state_d = S_APPLY;
                        pat_d   = pat_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change cleanly on the edge.
        busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_CHECK);
        done_d = (state_d == S_DONE);
        a_d    = busy_d ? {NCELL{pat_d[1]}} : '0;
        b_d    = busy_d ? {NCELL{pat_d[0]}} : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= 2'd0;
            wait_q  <= 4'd0;
            fail_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            wait_q  <= wait_d;
            fail_q  <= fail_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.dut_a     = a_q;
    assign bus.dut_b     = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = fail_q;
    assign bus.dbg_state = state_q;

`ifdef NOR2_BIST_ERRCNT_EN
    logic       clear_run;
    logic       check_en;
    logic [5:0] pop;
    logic [8:0] sum;
    logic [7:0] err_q, err_d;

    // An aborted CHECK does not accumulate, matching fail_mask.
    assign clear_run = (state_q == S_IDLE) && bus.start && !bus.abort;
    assign check_en  = (state_q == S_CHECK) && !bus.abort;

    always_comb begin
        pop = 6'd0;
        for (int i = 0; i < NCELL; i++) begin
            pop = pop + 6'(mism[i]);
        end
        sum   = {1'b0, err_q} + 9'(pop);
        err_d = err_q;
        if (clear_run) begin
            err_d = 8'd0;
        end else if (check_en) begin
            err_d = sum[8] ? 8'hFF : sum[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 8'd0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = 8'd0;
`endif

endmodule

// File: tb/tb_nor2_bist_ctrl.sv
// Directed bench for nor2_bist_ctrl: NOR cell model with stuck-at faults,
// scoreboard of expected run results, SETTLE=2 and SETTLE=5 instances.
`timescale 1ns/1ps

module tb_nor2_bist_ctrl;
    localparam int NCELL = 8;
    localparam int W     = 1 + NCELL + 8;
    localparam int ST_IDLE   = 0;
    localparam int ST_APPLY  = 1;
    localparam int ST_SETTLE = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             sel;
    logic             start_i;
    logic             abort_i;
    logic [NCELL-1:0] sa1;
    logic [NCELL-1:0] sa0;

    nor2_bist_ctrl_if #(.NCELL(NCELL)) bus2 ();
    nor2_bist_ctrl_if #(.NCELL(NCELL)) bus5 ();

    nor2_bist_ctrl #(.NCELL(NCELL), .SETTLE(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    nor2_bist_ctrl #(.NCELL(NCELL), .SETTLE(5)) dut5 (.clk(clk), .reset(reset), .bus(bus5.slave));

    assign bus2.start = start_i & ~sel;
    assign bus5.start = start_i & sel;
    assign bus2.abort = abort_i & ~sel;
    assign bus5.abort = abort_i & sel;

    // NOR2 cells with per-cell stuck-at-1 / stuck-at-0 faults
    assign bus2.dut_y = (~(bus2.dut_a | bus2.dut_b) | sa1) & ~sa0;
    assign bus5.dut_y = (~(bus5.dut_a | bus5.dut_b) | sa1) & ~sa0;

    logic             o_busy, o_done, o_pass;
    logic [NCELL-1:0] o_mask, o_a, o_b;
    logic [7:0]       o_err;
    logic [2:0]       o_state;
    assign o_busy  = sel ? bus5.busy      : bus2.busy;
    assign o_done  = sel ? bus5.done      : bus2.done;
    assign o_pass  = sel ? bus5.pass      : bus2.pass;
    assign o_mask  = sel ? bus5.fail_mask : bus2.fail_mask;
    assign o_err   = sel ? bus5.err_count : bus2.err_count;
    assign o_state = sel ? bus5.dbg_state : bus2.dbg_state;
    assign o_a     = sel ? bus5.dut_a     : bus2.dut_a;
    assign o_b     = sel ? bus5.dut_b     : bus2.dut_b;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected {pass, fail_mask, err_count} of one full run against the cell model
    function automatic logic [W-1:0] model_run(input logic [NCELL-1:0] f1, input logic [NCELL-1:0] f0);
        logic [NCELL-1:0] ideal, y, m, acc;
        int errs;
        acc  = '0;
        errs = 0;
        for (int p = 0; p < 4; p++) begin
            ideal = {NCELL{~(p[1] | p[0])}};
            y     = (ideal | f1) & ~f0;
            m     = y ^ ideal;
            acc   = acc | m;
            errs  = errs + $countones(m);
        end
        if (errs > 255) errs = 255;
`ifdef NOR2_BIST_ERRCNT_EN
        return {(acc == '0), acc, 8'(errs)};
`else
        return {(acc == '0), acc, 8'd0};
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(o_state), ST_IDLE);
        check({tag, "_busy"},  32'(o_busy), 0);
        check({tag, "_done"},  32'(o_done), 0);
        check({tag, "_ab"},    32'({o_a, o_b}), 0);
    endtask

    task automatic run(input logic s, input int settle, input logic [NCELL-1:0] f1,
                       input logic [NCELL-1:0] f0, input logic poke_done, input string tag);
        int cyc;
        int hold[4];
        logic [1:0] pat, last;
        logic bc_ok, ord_ok;
        logic [W-1:0] e;
        sel = s;
        sa1 = f1;
        sa0 = f0;
        exp_q.push_back(model_run(f1, f0));
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        hold   = '{default: 0};
        bc_ok  = 1'b1;
        ord_ok = 1'b1;
        last   = 2'd0;
        cyc    = 0;
        while (!o_done && cyc < 200) begin
            pat = {o_a[0], o_b[0]};
            if (!o_busy || o_a != {NCELL{pat[1]}} || o_b != {NCELL{pat[0]}}) bc_ok = 1'b0;
            if (pat != last && pat != last + 2'd1) ord_ok = 1'b0;
            last = pat;
            hold[pat]++;
            step();
            cyc++;
        end
        // latency counted to the rising edge at which done is captured
        check({tag, "_latency"}, cyc + 1, 4 * (settle + 2) + 1);
        check({tag, "_broadcast"}, 32'(bc_ok), 1);
        check({tag, "_order"}, 32'(ord_ok), 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_hold%0d", tag, k), hold[k], settle + 2);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_pass"}, 32'(o_pass), 32'(e[W-1]));
            check({tag, "_mask"}, 32'(o_mask), 32'(e[W-2:8]));
            check({tag, "_err"},  32'(o_err),  32'(e[7:0]));
        end
        check({tag, "_ab_done"}, 32'({o_a, o_b, o_busy}), 0);
        if (poke_done) start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_idle({tag, "_post"});
        step();
        check_idle({tag, "_post2"});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic seen;
        int k;
        sel = 1'b0; start_i = 1'b0; abort_i = 1'b0; sa1 = '0; sa0 = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset_pass", 32'(o_pass), 0);
        check("reset_mask", 32'(o_mask), 0);
        check("reset_err",  32'(o_err), 0);
        reset = 1'b0;
        step();
        check_idle("after_reset");

        // ideal cells, plus a start pulse during DONE that must be dropped
        run(1'b0, 2, '0, '0, 1'b1, "ideal");
        check("ideal_pass_kept", 32'(o_pass), 1);
        check("ideal_mask_kept", 32'(o_mask), 0);

        run(1'b0, 2, 8'h08, '0, 1'b0, "c3_sa1");
        check("c3_sa1_mask_const", 32'(o_mask), 'h08);
`ifdef NOR2_BIST_ERRCNT_EN
        check("c3_sa1_err_const", 32'(o_err), 3);
`else
        check("c3_sa1_err_const", 32'(o_err), 0);
`endif
        run(1'b0, 2, '0, 8'hFF, 1'b0, "all_sa0");
        check("all_sa0_mask_const", 32'(o_mask), 'hFF);

        // abort during SETTLE of pattern 10, cell 0 faulty
        sa1 = 8'h01; sa0 = '0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        k = 0;
        while (!o_a[0] && k < 50) begin
            step();
            k++;
        end
        check("abort_reach_p10", 32'({o_a[0], o_b[0]}), 'b10);
        step();
        check("abort_in_settle", 32'(o_state), ST_SETTLE);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_idle("abort");
        check("abort_pass", 32'(o_pass), 0);
        check("abort_mask", 32'(o_mask), 'h01);
`ifdef NOR2_BIST_ERRCNT_EN
        check("abort_err", 32'(o_err), 1);
`else
        check("abort_err", 32'(o_err), 0);
`endif
        seen = 1'b0;
        repeat (25) begin
            step();
            if (o_done) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 0);

        // start and abort together in IDLE: abort wins, results untouched
        start_i = 1'b1; abort_i = 1'b1;
        step();
        start_i = 1'b0; abort_i = 1'b0;
        check_idle("start_abort");
        check("start_abort_mask", 32'(o_mask), 'h01);
        step();
        check("start_abort_still_idle", 32'(o_state), ST_IDLE);

        // extra start mid-run is ignored; reset at cycle 9 clears everything at once
        sa1 = '0; sa0 = 8'h10;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (4) step();
        check("midrun_apply_p01", 32'(o_state), ST_APPLY);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("midrun_start_ignored_state", 32'(o_state), ST_SETTLE);
        check("midrun_start_ignored_ab", 32'({o_a, o_b}), 32'({{NCELL{1'b0}}, {NCELL{1'b1}}}));
        check("midrun_mask", 32'(o_mask), 'h10);
        repeat (3) step();
        check("midrun_busy", 32'(o_busy), 1);
        #2 reset = 1'b1;
        #1;
        check_idle("async_reset");
        check("async_reset_pass", 32'(o_pass), 0);
        check("async_reset_mask", 32'(o_mask), 0);
        check("async_reset_err",  32'(o_err), 0);
        step();
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            step();
            if (o_done || o_busy) seen = 1'b1;
        end
        check("reset_no_done", 32'(seen), 0);

        // SETTLE=5 instance: 29-cycle latency and 7-cycle pattern hold
        run(1'b1, 5, '0, 8'h24, 1'b0, "settle5");
        sel = 1'b0;

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, expected end of sequence");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nor2_bist_ctrl.md
NOR2_BIST_CTRL -- requirements
Module: nor2_bist_ctrl

Interface
REQ-001 The block SHALL have parameter NCELL, default 8, giving the number of NOR2X1 cells under test (1..32).
REQ-002 The block SHALL have parameter SETTLE, default 2, giving the wait cycles between pattern apply and check (1..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a test run.
REQ-006 The block SHALL have port abort, input, 1, a synchronous request to cancel a run in progress.
REQ-007 The block SHALL have port dut_a, output, NCELL, the A inputs of the cells under test.
REQ-008 The block SHALL have port dut_b, output, NCELL, the B inputs of the cells under test.
REQ-009 The block SHALL have port dut_y, input, NCELL, the Y outputs of the cells under test.
REQ-010 The block SHALL have port busy, output, 1, high while a run is in progress.
REQ-011 The block SHALL have port done, output, 1, a one-cycle pulse on run completion.
REQ-012 The block SHALL have port pass, output, 1, high when the last completed run had zero mismatches.
REQ-013 The block SHALL have port fail_mask, output, NCELL, holding the sticky per-cell mismatch flags.
REQ-014 The block SHALL have port err_count, output, 8, the saturating count of mismatches.

Function
REQ-015 The FSM SHALL have states IDLE, APPLY, SETTLE, CHECK and DONE.
REQ-016 In IDLE, start=1 SHALL move to APPLY on the next cycle and clear fail_mask, pass, err_count and the 2-bit pattern counter.
REQ-017 APPLY SHALL last 1 cycle, SETTLE exactly SETTLE cycles, and CHECK 1 cycle.
REQ-018 Patterns SHALL be applied in the order {a,b} = 00, 01, 10, 11, each broadcast to all NCELL bits of dut_a/dut_b.
REQ-019 dut_a/dut_b SHALL hold the current pattern from APPLY through CHECK, and be 0 in IDLE and DONE.
REQ-020 In CHECK, each bit i with dut_y[i] != ~(a|b) SHALL set fail_mask[i] (OR-accumulate).
REQ-021 In CHECK, err_count SHALL add the popcount of the mismatches, saturating at 255.
REQ-022 CHECK with pattern 11 SHALL go to DONE; otherwise it SHALL increment the pattern and go to APPLY.
REQ-023 DONE SHALL last 1 cycle with done=1 and pass = (fail_mask==0) latched, then go to IDLE.
REQ-024 busy SHALL be 1 in APPLY, SETTLE and CHECK, and 0 in IDLE and DONE.
REQ-025 start SHALL be ignored unless the FSM is in IDLE; start arriving during DONE SHALL be dropped.
REQ-026 abort=1 in APPLY, SETTLE or CHECK SHALL go to IDLE next cycle with no done pulse, pass=0, and fail_mask/err_count retained.
REQ-027 If start and abort are both high in IDLE, abort SHALL win and the run SHALL NOT start.
REQ-028 Run latency from the start-accepting edge to the done pulse SHALL be 4*(SETTLE+2)+1 cycles (17 at default).

Reset
REQ-029 reset=1 SHALL force state IDLE, the pattern counter to 0, dut_a=dut_b=0, busy=done=pass=0, fail_mask=0 and err_count=0, immediately and asynchronously.
REQ-030 Reset asserted mid-run SHALL discard the run, and no done pulse SHALL follow the release of reset.

Configuration
REQ-031 Macro NOR2_BIST_ERRCNT_EN defined SHALL implement the err_count accumulator per REQ-021.
REQ-032 Without NOR2_BIST_ERRCNT_EN, err_count SHALL be constant 0, no counter logic SHALL be synthesised, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Ideal NOR model on all 8 cells, start pulse -> done 17 cycles later, pass=1, fail_mask=0x00, err_count=0.
REQ-034 Cell 3 stuck-at-1 -> fails on patterns 01, 10 and 11, giving fail_mask=0x08, pass=0, err_count=3 (0 without the macro).
REQ-035 All cells stuck-at-0 -> fails on pattern 00 only, giving fail_mask=0xFF and err_count=8.
REQ-036 abort in SETTLE of pattern 10 with cell 0 faulty -> IDLE next cycle, no done pulse, busy=0, fail_mask=0x01 retained.
REQ-037 Second start pulse during a run, then reset asserted at cycle 9 -> the extra start is ignored, and all outputs are 0 asynchronously.
REQ-038 SETTLE=5 with a start pulse -> done after 29 cycles, and each pattern is held for 7 cycles on dut_a/dut_b.
